// File: rtl/rv32_dmem_pmp_guard.sv
// Data-memory request stage: registers LSU requests, checks them against rv32_mpu permissions
// and either forwards them to memory or raises an access fault. Optional alignment check:
// DMEM_PMP_GUARD_MISALIGN_EN.
module rv32_dmem_pmp_guard #(
  parameter int unsigned XLEN   = 32,
  parameter logic [1:0]  PRIV_M = 2'b11
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [XLEN-1:0]   req_addr,
  input  logic              req_wr,
  input  logic [1:0]        req_size,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [XLEN/8-1:0] req_strb,
  input  logic [1:0]        priv_mode,
  output logic [XLEN-1:0]   mpu_addr,
  input  logic [3:0]        mpu_allow,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [XLEN-1:0]   mem_addr,
  output logic              mem_wr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_strb,
  output logic              fault_valid,
  input  logic              fault_ready,
  output logic [3:0]        fault_cause,
  output logic [XLEN-1:0]   fault_tval
);

  typedef enum logic [1:0] {StIdle, StChk, StFwd, StFault} state_e;

  state_e              r_state;
  state_e              w_state_nxt;
  logic [XLEN-1:0]     r_addr;
  logic                r_wr;
  logic [XLEN-1:0]     r_wdata;
  logic [XLEN/8-1:0]   r_strb;
  logic [1:0]          r_priv;
  logic [3:0]          r_cause;
  logic [XLEN-1:0]     r_tval;

  logic                w_capture;
  logic                w_ready;
  logic                w_perm;
  logic                w_deny;
  logic                w_fault;
  logic [3:0]          w_cause;
  logic                w_unused_x;

  assign w_unused_x = mpu_allow[2];

  // M-mode only honours the permission bits of locked regions.
  assign w_perm = r_wr ? mpu_allow[1] : mpu_allow[0];
  assign w_deny = (r_priv == PRIV_M) ? (mpu_allow[3] & ~w_perm) : ~w_perm;

`ifdef DMEM_PMP_GUARD_MISALIGN_EN
  logic [1:0] r_size;
  logic       w_misalign;

  assign w_misalign = ((r_size == 2'd1) && r_addr[0]) ||
                      ((r_size == 2'd2) && (r_addr[1:0] != 2'b00));

  always_comb begin
    w_fault = 1'b0;
    w_cause = 4'd0;
    if (w_misalign) begin
      w_fault = 1'b1;
      w_cause = r_wr ? 4'd6 : 4'd4;
    end else if (w_deny) begin
      w_fault = 1'b1;
      w_cause = r_wr ? 4'd7 : 4'd5;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_size <= 2'd0;
    end else if (w_capture) begin
      r_size <= req_size;
    end
  end
`else
  logic w_unused_size;

  assign w_unused_size = ^req_size;

  always_comb begin
    w_fault = w_deny;
    w_cause = r_wr ? 4'd7 : 4'd5;
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_ready     = 1'b0;
    mem_valid   = 1'b0;
    fault_valid = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_ready = 1'b1;
        if (req_valid) begin
          w_capture   = 1'b1;
          w_state_nxt = StChk;
        end
      end
      StChk: begin
        w_state_nxt = w_fault ? StFault : StFwd;
      end
      StFwd: begin
        mem_valid = 1'b1;
        w_ready   = mem_ready;
        if (mem_ready) begin
          if (req_valid) begin
            w_capture   = 1'b1;
            w_state_nxt = StChk;
          end else begin
            w_state_nxt = StIdle;
          end
        end
      end
      StFault: begin
        fault_valid = 1'b1;
        if (fault_ready) begin
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
    req_ready = w_ready & aresetn;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= StIdle;
      r_addr  <= '0;
      r_wr    <= 1'b0;
      r_wdata <= '0;
      r_strb  <= '0;
      r_priv  <= 2'b00;
      r_cause <= 4'd0;
      r_tval  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_capture) begin
        r_addr  <= req_addr;
        r_wr    <= req_wr;
        r_wdata <= req_wdata;
        r_strb  <= req_strb;
        r_priv  <= priv_mode;
      end
      if ((r_state == StChk) && w_fault) begin
        r_cause <= w_cause;
        r_tval  <= r_addr;
      end
    end
  end

  assign mpu_addr    = r_addr;
  assign mem_addr    = r_addr;
  assign mem_wr      = r_wr;
  assign mem_wdata   = r_wdata;
  assign mem_strb    = r_strb;
  assign fault_cause = r_cause;
  assign fault_tval  = r_tval;

endmodule

// File: tb/tb_rv32_dmem_pmp_guard.sv
// Self-checking bench for rv32_dmem_pmp_guard: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a transaction-level model.
module tb_rv32_dmem_pmp_guard;

`ifdef DMEM_PMP_GUARD_MISALIGN_EN
  localparam bit MisEn = 1'b1;
`else
  localparam bit MisEn = 1'b0;
`endif

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        req_wr = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_strb = '0;
  logic [1:0]  priv_mode = 2'b00;
  logic [31:0] mpu_addr;
  logic [3:0]  mpu_allow = 4'h0;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_strb;
  logic        fault_valid;
  logic        fault_ready = 1'b0;
  logic [3:0]  fault_cause;
  logic [31:0] fault_tval;

  int n_checks = 0;
  int n_errors = 0;

  rv32_dmem_pmp_guard dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_wr      (req_wr),
    .req_size    (req_size),
    .req_wdata   (req_wdata),
    .req_strb    (req_strb),
    .priv_mode   (priv_mode),
    .mpu_addr    (mpu_addr),
    .mpu_allow   (mpu_allow),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .mem_addr    (mem_addr),
    .mem_wr      (mem_wr),
    .mem_wdata   (mem_wdata),
    .mem_strb    (mem_strb),
    .fault_valid (fault_valid),
    .fault_ready (fault_ready),
    .fault_cause (fault_cause),
    .fault_tval  (fault_tval)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Verdict from the access rules: 0 means forward, otherwise the mcause code.
  function automatic logic [3:0] decide(input logic [31:0] a, input logic wr,
                                        input logic [1:0] sz, input logic [1:0] pv,
                                        input logic [3:0] al);
    bit perm;
    bit deny;
    bit mis;
    perm = wr ? al[1] : al[0];
    if (pv == 2'b11) deny = al[3] && !perm;
    else             deny = !perm;
    mis = (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
    if (MisEn && mis) return wr ? 4'd6 : 4'd4;
    if (deny)         return wr ? 4'd7 : 4'd5;
    return 4'd0;
  endfunction

  // Transaction-level model: one request held, first its check cycle, then its verdict.
  logic        m_busy = 1'b0;
  logic        m_checked = 1'b0;
  logic [3:0]  m_cause = 4'd0;
  logic [31:0] m_addr = '0;
  logic        m_wr = 1'b0;
  logic [1:0]  m_size = 2'd0;
  logic [31:0] m_wdata = '0;
  logic [3:0]  m_strb = '0;
  logic [1:0]  m_priv = 2'b00;

  wire exp_mem = m_busy && m_checked && (m_cause == 4'd0);
  wire exp_flt = m_busy && m_checked && (m_cause != 4'd0);
  wire exp_rdy = !m_busy || (exp_mem && mem_ready);

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_busy <= 1'b0; m_checked <= 1'b0; m_cause <= 4'd0; m_addr <= '0; m_wr <= 1'b0;
      m_size <= 2'd0; m_wdata <= '0; m_strb <= '0; m_priv <= 2'b00;
    end else if (exp_rdy && req_valid) begin
      m_busy <= 1'b1; m_checked <= 1'b0; m_addr <= req_addr; m_wr <= req_wr;
      m_size <= req_size; m_wdata <= req_wdata; m_strb <= req_strb; m_priv <= priv_mode;
    end else if (m_busy && !m_checked) begin
      m_cause   <= decide(m_addr, m_wr, m_size, m_priv, mpu_allow);
      m_checked <= 1'b1;
    end else if ((exp_mem && mem_ready) || (exp_flt && fault_ready)) begin
      m_busy <= 1'b0;
    end
  end

  always @(negedge aclk) begin
    if (!aresetn) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_mem_valid", mem_valid, 0);
      chk("rst_fault_valid", fault_valid, 0);
    end else begin
      chk("mem_valid", mem_valid, exp_mem);
      chk("fault_valid", fault_valid, exp_flt);
      chk("req_ready", req_ready, exp_rdy);
      chk("mpu_addr", mpu_addr, m_addr);
      if (exp_mem) begin
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wr", mem_wr, m_wr);
        chk("mem_wdata", mem_wdata, m_wdata);
        chk("mem_strb", mem_strb, m_strb);
      end
      if (exp_flt) begin
        chk("fault_cause", fault_cause, m_cause);
        chk("fault_tval", fault_tval, m_addr);
      end
    end
  end

  task automatic wait_idle;
    int n;
    n = 0;
    @(negedge aclk);
    #1;
    req_valid   = 1'b0;
    mem_ready   = 1'b1;
    fault_ready = 1'b1;
    while (n < 50) begin
      @(negedge aclk);
      if (!mem_valid && !fault_valid && req_ready) break;
      n++;
    end
    chk("idle_reached", (n < 50), 1);
  endtask

  // Issues one request from idle and returns at the cycle its outcome must be visible.
  task automatic send(input logic [31:0] a, input logic wr, input logic [1:0] sz,
                      input logic [1:0] pv, input logic [3:0] al);
    #1;
    req_valid = 1'b1; req_addr = a; req_wr = wr; req_size = sz; priv_mode = pv;
    req_wdata = a ^ 32'hA5A5_0000; req_strb = 4'hF; mpu_allow = al;
    mem_ready = 1'b0; fault_ready = 1'b0;
    @(posedge aclk);
    #1;
    req_valid = 1'b0;
    @(negedge aclk);
    chk("lat_early", {31'd0, mem_valid | fault_valid}, 0);
    @(negedge aclk);
  endtask

  initial begin
    int v;
    repeat (2) @(negedge aclk);
    chk("rst_lit_req_ready", req_ready, 0);
    chk("rst_lit_fault_cause", fault_cause, 0);
    chk("rst_lit_fault_tval", fault_tval, 0);
    chk("rst_lit_mpu_addr", mpu_addr, 0);
    chk("rst_lit_mem_addr", mem_addr, 0);
    #1 aresetn = 1'b1;

    // U-mode load with MPU off
    wait_idle();
    send(32'h0000_1000, 1'b0, 2'd2, 2'b00, 4'h7);
    chk("t1_mem_valid", mem_valid, 1);
    chk("t1_mem_addr", mem_addr, 32'h0000_1000);
    chk("t1_mem_wr", mem_wr, 0);
    chk("t1_fault_valid", fault_valid, 0);

    // U-mode store denied, fault held while not consumed
    wait_idle();
    send(32'h0000_2004, 1'b1, 2'd2, 2'b00, 4'b0001);
    #1 mpu_allow = 4'h7;
    for (int i = 0; i < 4; i++) begin
      chk("t2_fault_valid", fault_valid, 1);
      chk("t2_cause", fault_cause, 7);
      chk("t2_tval", fault_tval, 32'h0000_2004);
      chk("t2_mem_valid", mem_valid, 0);
      @(negedge aclk);
    end

    // M-mode: only locked regions restrict
    wait_idle();
    send(32'h0000_3000, 1'b1, 2'd2, 2'b11, 4'b0001);
    chk("t3a_mem_valid", mem_valid, 1);
    wait_idle();
    send(32'h0000_3004, 1'b1, 2'd2, 2'b11, 4'b1001);
    chk("t3b_cause", fault_cause, 7);
    wait_idle();
    send(32'h0000_3008, 1'b0, 2'd2, 2'b11, 4'b1000);
    chk("t3c_cause", fault_cause, 5);
    chk("t3c_tval", fault_tval, 32'h0000_3008);

    // Memory back-pressure then back-to-back acceptance
    wait_idle();
    send(32'h0000_4000, 1'b1, 2'd2, 2'b00, 4'h7);
    repeat (4) begin
      chk("t4_mem_addr", mem_addr, 32'h0000_4000);
      chk("t4_mem_wdata", mem_wdata, 32'hA5A5_4000);
      @(negedge aclk);
    end
    #1;
    mem_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h0000_5000; req_wr = 1'b0;
    #1 chk("t4_req_ready", req_ready, 1);
    @(posedge aclk);
    #1;
    req_valid = 1'b0; mem_ready = 1'b0;
    @(negedge aclk);
    chk("t4_gap", mem_valid, 0);
    @(negedge aclk);
    chk("t4_mem_valid2", mem_valid, 1);
    chk("t4_mem_addr2", mem_addr, 32'h0000_5000);

    // Reset during forward drops the request silently
    wait_idle();
    send(32'h0000_6000, 1'b0, 2'd2, 2'b00, 4'h7);
    #1 aresetn = 1'b0;
    #1;
    chk("t5_mem_valid", mem_valid, 0);
    chk("t5_fault_valid", fault_valid, 0);
    chk("t5_req_ready", req_ready, 0);
    @(posedge aclk);
    #2 aresetn = 1'b1;
    @(negedge aclk);
    chk("t5_idle_ready", req_ready, 1);
    chk("t5_no_fault", fault_valid, 0);

    // Misaligned accesses
    wait_idle();
    send(32'h0000_1002, 1'b0, 2'd2, 2'b00, 4'h7);
    if (MisEn) chk("t6_cause", fault_cause, 4);
    else       chk("t6_fwd_addr", mem_addr, 32'h0000_1002);
    chk("t6_fault_valid", fault_valid, MisEn);
    wait_idle();
    send(32'h0000_1001, 1'b1, 2'd1, 2'b00, 4'h0);
    chk("t6_store_cause", fault_cause, MisEn ? 6 : 7);

    // Randomized traffic
    wait_idle();
    for (int c = 0; c < 3000; c++) begin
      @(negedge aclk);
      #1;
      req_valid   = ($urandom_range(0, 9) < 7);
      req_addr    = $urandom;
      req_wr      = $urandom_range(0, 1) == 1;
      req_size    = 2'($urandom_range(0, 2));
      req_wdata   = $urandom;
      req_strb    = 4'($urandom);
      v           = $urandom_range(0, 2);
      priv_mode   = (v == 2) ? 2'b11 : 2'(v);
      mpu_allow   = 4'($urandom);
      mem_ready   = ($urandom_range(0, 9) < 6);
      fault_ready = $urandom_range(0, 1) == 1;
    end
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
